// File: rtl/atm_controller.sv
// ATM transaction controller: card session, 4-digit PIN check with 3-attempt
// lockout, and one deposit/withdrawal per session against a 64-bit balance.
module atm_controller #(
  parameter logic [15:0] PIN          = 16'h4756,
  parameter logic [63:0] BALANCE_INIT = 64'd10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tarjeta_recibida,
  input  logic        add_digit,
  input  logic [3:0]  digito,
  input  logic        digito_stb,
  input  logic        tipo_trans,
  input  logic        monto_stb,
  input  logic [31:0] monto,
  output logic        balance_actualizado,
  output logic        entregar_dinero,
  output logic        pin_incorrecto,
  output logic        advertencia,
  output logic        bloqueo,
  output logic        fondos_insuficientes
);

  typedef enum logic [1:0] {
    ESPERA_TARJETA = 2'd0,
    INGRESO_PIN    = 2'd1,
    ESPERA_MONTO   = 2'd2,
    BLOQUEO        = 2'd3
  } state_t;

  state_t      state_r;
  logic [63:0] balance_r;
  logic [15:0] pin_buf_r;
  logic [2:0]  digit_cnt_r;
  logic [1:0]  attempts_r;

  logic tarjeta_prev_r;
  logic add_digit_prev_r;
  logic digito_stb_prev_r;
  logic monto_stb_prev_r;

  logic        tarjeta_edge_s;
  logic        add_digit_edge_s;
  logic        digito_stb_edge_s;
  logic        monto_stb_edge_s;
  logic [63:0] monto_ext_s;

  // Rising-edge detection against the previous registered sample
  assign tarjeta_edge_s    = tarjeta_recibida & ~tarjeta_prev_r;
  assign add_digit_edge_s  = add_digit        & ~add_digit_prev_r;
  assign digito_stb_edge_s = digito_stb       & ~digito_stb_prev_r;
  assign monto_stb_edge_s  = monto_stb        & ~monto_stb_prev_r;
  assign monto_ext_s       = {32'd0, monto};

  // Session FSM, balance register, edge history and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r              <= ESPERA_TARJETA;
      balance_r            <= BALANCE_INIT;
      pin_buf_r            <= 16'd0;
      digit_cnt_r          <= 3'd0;
      attempts_r           <= 2'd0;
      tarjeta_prev_r       <= 1'b0;
      add_digit_prev_r     <= 1'b0;
      digito_stb_prev_r    <= 1'b0;
      monto_stb_prev_r     <= 1'b0;
      balance_actualizado  <= 1'b0;
      entregar_dinero      <= 1'b0;
      pin_incorrecto       <= 1'b0;
      advertencia          <= 1'b0;
      bloqueo              <= 1'b0;
      fondos_insuficientes <= 1'b0;
    end else begin
      tarjeta_prev_r       <= tarjeta_recibida;
      add_digit_prev_r     <= add_digit;
      digito_stb_prev_r    <= digito_stb;
      monto_stb_prev_r     <= monto_stb;
      balance_actualizado  <= 1'b0;
      entregar_dinero      <= 1'b0;
      pin_incorrecto       <= 1'b0;
      fondos_insuficientes <= 1'b0;

      case (state_r)
        ESPERA_TARJETA: begin
          bloqueo <= 1'b0;
          if (tarjeta_edge_s) begin
            state_r     <= INGRESO_PIN;
            pin_buf_r   <= 16'd0;
            digit_cnt_r <= 3'd0;
            attempts_r  <= 2'd0;
          end
        end

        INGRESO_PIN: begin
          // Verification takes priority; a digit arriving on the same edge is dropped
          if (digito_stb_edge_s) begin
            pin_buf_r   <= 16'd0;
            digit_cnt_r <= 3'd0;
            if ((digit_cnt_r == 3'd4) && (pin_buf_r == PIN)) begin
              state_r <= ESPERA_MONTO;
            end else begin
              attempts_r     <= attempts_r + 2'd1;
              pin_incorrecto <= 1'b1;
              if (attempts_r == 2'd1) begin
                advertencia <= 1'b1;
              end else if (attempts_r == 2'd2) begin
                advertencia <= 1'b1;
                bloqueo     <= 1'b1;
                state_r     <= BLOQUEO;
              end
            end
          end else if (add_digit_edge_s && (digit_cnt_r != 3'd4)) begin
            pin_buf_r   <= {pin_buf_r[11:0], digito};
            digit_cnt_r <= digit_cnt_r + 3'd1;
          end
        end

        ESPERA_MONTO: begin
          if (monto_stb_edge_s) begin
            state_r     <= ESPERA_TARJETA;
            advertencia <= 1'b0;
            if (!tipo_trans) begin
              balance_r           <= balance_r + monto_ext_s;
              balance_actualizado <= 1'b1;
            end else if (monto_ext_s <= balance_r) begin
              balance_r           <= balance_r - monto_ext_s;
              balance_actualizado <= 1'b1;
              entregar_dinero     <= 1'b1;
            end else begin
              fondos_insuficientes <= 1'b1;
            end
          end
        end

        BLOQUEO: begin
          bloqueo     <= 1'b1;
          advertencia <= 1'b1;
        end

        default: begin
          state_r <= ESPERA_TARJETA;
        end
      endcase
    end
  end

endmodule
